// File: rtl/dct_transpose8x8.sv
// dct_transpose8x8
// Row/column transpose buffer between the two 1-D DCT (or IDCT) passes.
// Accepts one 8-sample row per handshake. Once a full 8x8 block is stored,
// it emits that block one column per handshake.
//
// Build option:
//   DCT_TRANSPOSE_PINGPONG_EN defined   -> two banks, full-rate streaming
//                                          (one row in and one column out per cycle).
//   DCT_TRANSPOSE_PINGPONG_EN undefined -> single bank; input stalls while a
//                                          block drains.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset; clears state and storage
//   s_valid_i  input row valid
//   s_ready_o  input row accepted when s_valid_i && s_ready_o
//   s_data_i   row r; element c is sample (r,c)
//   m_valid_o  output column valid
//   m_ready_i  downstream ready
//   m_data_o   column c; element r is sample (r,c); muxed from storage
module dct_transpose8x8 #(
    parameter int unsigned DataWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [0:7][DataWidth-1:0] s_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [0:7][DataWidth-1:0] m_data_o
);

    localparam int unsigned Dim  = 8;
    localparam int unsigned IdxW = 3;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam int unsigned NumBanks = 2;
    localparam bit          PingPong = 1'b1;
`else
    localparam int unsigned NumBanks = 1;
    localparam bit          PingPong = 1'b0;
`endif

    // Storage is indexed [bank][row][col]. Columns are declared ascending so
    // that a whole input row can be written in a single assignment.
    logic [NumBanks-1:0][Dim-1:0][0:Dim-1][DataWidth-1:0] mem_q;

    // Each bank has its own EMPTY/FILLING/FULL/DRAINING state.
    // Only the full flag is stored. FILLING and DRAINING are implied by
    // the wb/rb pointers together with the row and column counters.
    logic [NumBanks-1:0] full_q, full_d;
    logic                wb_q, wb_d;
    logic                rb_q, rb_d;
    logic [IdxW-1:0]     wr_row_q, wr_row_d;
    logic [IdxW-1:0]     rd_col_q, rd_col_d;
    logic                wr_en, rd_en;

    // State register and bank storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q   <= '0;
            wb_q     <= 1'b0;
            rb_q     <= 1'b0;
            wr_row_q <= '0;
            rd_col_q <= '0;
            mem_q    <= '0;
        end else begin
            full_q   <= full_d;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
            if (wr_en) begin
                mem_q[wb_q][wr_row_q] <= s_data_i;
            end
        end
    end

    // Next-state logic. While both sides are active they use different
    // banks, so the set and clear of the full flags never collide.
    always_comb begin
        wr_en    = s_valid_i && s_ready_o;
        rd_en    = m_valid_o && m_ready_i;
        full_d   = full_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        wr_row_d = wr_row_q;
        rd_col_d = rd_col_q;

        if (wr_en) begin
            wr_row_d = wr_row_q + IdxW'(1);
            if (wr_row_q == IdxW'(Dim - 1)) begin
                full_d[wb_q] = 1'b1;
                wb_d         = PingPong ? !wb_q : 1'b0;
            end
        end

        if (rd_en) begin
            rd_col_d = rd_col_q + IdxW'(1);
            if (rd_col_q == IdxW'(Dim - 1)) begin
                full_d[rb_q] = 1'b0;
                rb_d         = PingPong ? !rb_q : 1'b0;
            end
        end
    end

    // Handshake outputs. These come from registered flags only and are
    // forced low while reset is asserted.
    always_comb begin
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        if (!rst_i) begin
            s_ready_o = !full_q[wb_q];
            m_valid_o = full_q[rb_q];
        end
    end

    // Column read mux. It depends on registered state only. Storage is
    // cleared asynchronously, so the output reads 0 during reset.
    for (genvar r = 0; r < Dim; r++) begin : g_col
        assign m_data_o[r] = mem_q[rb_q][r][rd_col_q];
    end

endmodule

// File: tb/tb_dct_transpose8x8.sv
module tb_dct_transpose8x8;

    localparam int DW = 16;
    typedef logic [0:7][DW-1:0] vec_t;

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic s_ready;
    vec_t s_data = '0;
    logic m_valid;
    logic m_ready = 1'b1;
    vec_t m_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mr_mode  = 1;  // 0: hold low, 1: hold high, 2: random
    int cyc = 0, in_cnt = 0, out_cnt = 0, stall_cnt = 0;
    int first_out = 0, last_out = 0;

    vec_t part_rows[$];
    vec_t exp_cols[$];

    dct_transpose8x8 #(.DataWidth(DW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_data_i (s_data),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready),
        .m_data_o (m_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (mr_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model. Accepted rows collect into a block. A completed
    // block becomes 8 expected columns. Handshake outputs follow from the
    // number of complete, not-yet-drained blocks.
    always @(negedge clk) begin
        int   nblk;
        vec_t col;
        cyc++;
        if (rst) begin
            chk_bit("rst_s_ready", s_ready, 1'b0);
            chk_bit("rst_m_valid", m_valid, 1'b0);
            chk_vec("rst_m_data", m_data, '0);
            part_rows.delete();
            exp_cols.delete();
        end else begin
            nblk = (exp_cols.size() + 7) / 8;
            chk_bit("s_ready", s_ready, PP ? (nblk < 2) : (nblk == 0));
            chk_bit("m_valid", m_valid, exp_cols.size() != 0);
            if (m_valid && exp_cols.size() != 0)
                chk_vec("m_data", m_data, exp_cols[0]);
            if (s_valid && !s_ready) stall_cnt++;
            if (s_valid && s_ready) begin
                in_cnt++;
                part_rows.push_back(s_data);
                if (part_rows.size() == 8) begin
                    for (int c = 0; c < 8; c++) begin
                        for (int r = 0; r < 8; r++) col[r] = part_rows[r][c];
                        exp_cols.push_back(col);
                    end
                    part_rows.delete();
                end
            end
            if (m_valid && m_ready) begin
                if (exp_cols.size() != 0) void'(exp_cols.pop_front());
                if (out_cnt == 0) first_out = cyc;
                last_out = cyc;
                out_cnt++;
            end
        end
    end

    // Offer nrows rows. Row r, column c carries base+8r+c, or random values
    // with the two signed extremes placed in row 0.
    task automatic send_rows(input int base, input int nrows, input int pv, input bit rnd);
        int r = 0;
        int guard = 0;
        bit acc;
        while (r < nrows) begin
            s_valid = (int'($urandom_range(0, 99)) < pv);
            for (int c = 0; c < 8; c++)
                s_data[c] = rnd ? DW'($urandom) : DW'(base + 8 * r + c);
            if (rnd && r == 0) begin
                s_data[0] = 16'h8000;
                s_data[1] = 16'h7fff;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) r++;
            guard++;
            if (guard > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got %0d rows expected %0d", r, nrows);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_cols.size() != 0 || m_valid) && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: drain timeout, %0d columns left expected 0", name, exp_cols.size());
        end
    endtask

    initial begin
        vec_t lit;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_bit("reset_s_ready", s_ready, 1'b0);
        chk_bit("reset_m_valid", m_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_bit("post_reset_s_ready", s_ready, 1'b1);
        chk_bit("post_reset_m_valid", m_valid, 1'b0);

        // Single counting block. Column 0 must be valid one cycle after row 7.
        out_cnt = 0;
        send_rows(0, 8, 100, 1'b0);
        chk_bit("t1_latency_valid", m_valid, 1'b1);
        lit = {16'd0, 16'd8, 16'd16, 16'd24, 16'd32, 16'd40, 16'd48, 16'd56};
        chk_vec("t1_col0_literal", m_data, lit);
        repeat (7) @(posedge clk);
        #1;
        lit = {16'd7, 16'd15, 16'd23, 16'd31, 16'd39, 16'd47, 16'd55, 16'd63};
        chk_vec("t1_col7_literal", m_data, lit);
        chk_bit("t1_col7_valid", m_valid, 1'b1);
        @(posedge clk);
        #1;
        chk_bit("t1_valid_drops", m_valid, 1'b0);
        chk_int("t1_out_count", out_cnt, 8);

        // Three back-to-back blocks at full rate.
        out_cnt = 0;
        stall_cnt = 0;
        send_rows(0, 8, 100, 1'b0);
        send_rows(64, 8, 100, 1'b0);
        send_rows(128, 8, 100, 1'b0);
        wait_drain("t2_drain");
        chk_int("t2_out_count", out_cnt, 24);
        chk_int("t2_out_gaps", last_out - first_out + 1 - 24, PP ? 0 : 16);
        chk_int("t2_in_stalls", stall_cnt, PP ? 0 : 16);

        // Backpressure: m_ready held low for 20 cycles while 2 blocks are offered.
        mr_mode = 0;
        in_cnt = 0;
        out_cnt = 0;
        fork
            begin
                send_rows(256, 8, 100, 1'b0);
                send_rows(320, 8, 100, 1'b0);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                chk_int("t3_rows_before_stall", in_cnt, PP ? 16 : 8);
                chk_bit("t3_s_ready_low", s_ready, 1'b0);
                chk_bit("t3_m_valid_held", m_valid, 1'b1);
                lit = {16'h100, 16'h108, 16'h110, 16'h118, 16'h120, 16'h128, 16'h130, 16'h138};
                chk_vec("t3_col0_held", m_data, lit);
                mr_mode = 1;
            end
        join
        wait_drain("t3_drain");
        chk_int("t3_out_count", out_cnt, 16);

        // Random handshakes over 10 blocks of signed data.
        mr_mode = 2;
        out_cnt = 0;
        for (int b = 0; b < 10; b++) send_rows(0, 8, 50, 1'b1);
        mr_mode = 1;
        wait_drain("t4_drain");
        chk_int("t4_out_count", out_cnt, 80);

        // Reset mid-block with an undrained block present.
        mr_mode = 0;
        send_rows(512, 8, 100, 1'b0);
        if (PP) send_rows(576, 5, 100, 1'b0);
        chk_bit("t5_pre_reset_valid", m_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_bit("t5_async_s_ready", s_ready, 1'b0);
        chk_bit("t5_async_m_valid", m_valid, 1'b0);
        chk_vec("t5_async_m_data", m_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mr_mode = 1;
        out_cnt = 0;
        send_rows(768, 8, 100, 1'b0);
        lit = {16'h300, 16'h308, 16'h310, 16'h318, 16'h320, 16'h328, 16'h330, 16'h338};
        chk_vec("t5_fresh_col0", m_data, lit);
        wait_drain("t5_drain");
        chk_int("t5_out_count", out_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dct_transpose8x8.md
# dct_transpose8x8

Row/column transpose buffer for the 8x8 2D DCT datapath. It sits directly downstream of the row-pass `Dct1D` and upstream of the column-pass `Dct1D` (or between the two `IDct1D` passes). It accepts one 8-sample row per handshake and, once a full 8x8 block is stored, emits the block one column per handshake. Ping-pong storage allows a new block to be written while the previous one drains.

## Interface
- `DataWidth`, default 16: width of each sample; matches the `DoutWidth` of the upstream `Dct1D`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `s_valid_i`  in  1  input row valid.
- `s_ready_o`  out  1  input row accepted when `s_valid_i && s_ready_o`.
- `s_data_i`  in  [0:7][DataWidth-1:0]  row r; element c is sample (r,c).
- `m_valid_o`  out  1  output column valid.
- `m_ready_i`  in  1  downstream ready.
- `m_data_o`  out  [0:7][DataWidth-1:0]  column c; element r is sample (r,c).

## Operation
- Storage: two banks (B0, B1), each 8x8 x `DataWidth`, with a per-bank `full` flag.
- Write side: write-bank pointer `wb` and row counter `wr_row` (0..7).
  - On an accepted input, `s_data_i` goes to row `wr_row` of bank `wb`.
  - When `wr_row==7` and the row is accepted: set `full[wb]`, wrap `wr_row` to 0, toggle `wb`.
- Read side: read-bank pointer `rb` and column counter `rd_col` (0..7).
  - `m_data_o[r] = bank[rb][r][rd_col]`, muxed combinationally from storage.
  - On an accepted output, `rd_col` increments.
  - When `rd_col==7` and the column is accepted: clear `full[rb]`, wrap `rd_col` to 0, toggle `rb`.
- `s_ready_o = !full[wb] && !rst_i`.
- `m_valid_o = full[rb]`.
- Data is passed through bit-exact: no arithmetic, sign-agnostic.
- Per-bank state machine:
  - EMPTY -> FILLING on the first row written.
  - FILLING -> FULL on row 7 written.
  - FULL -> DRAINING on the first column read.
  - DRAINING -> EMPTY on column 7 read.
  - Only `full` is stored explicitly; FILLING/DRAINING are implied by `wb`/`rb` plus the counters.
- Boundary conditions:
  - Both banks full: `s_ready_o=0` until the read side clears `full[rb]`. Input is accepted again the cycle after that clear.
  - Same-edge completion: the write into `wb` and the read out of `rb` (different banks) complete independently. Both flag updates take effect on the same edge.
  - `m_ready_i` low with `m_valid_o` high: `m_data_o` and `rd_col` hold stable.
  - `s_valid_i` low mid-block: `wr_row` holds. Partial blocks are never emitted.
- Reset (asynchronous, also when asserted mid-block):
  - `wb=rb=0`, `wr_row=rd_col=0`, both `full` flags cleared.
  - Storage cleared to 0.
  - Any partial or undrained block is discarded.
- Output values during reset: `s_ready_o=0`, `m_valid_o=0`, `m_data_o=0`.

## Timing
- Latency: the first column is valid in the cycle after the edge that accepts row 7. There is no bubble beyond this.
- Throughput (ping-pong): 1 row in and 1 column out per cycle, sustained.
  - Back-to-back blocks stream with zero idle cycles when `m_ready_i=1`.
- Block turnaround: 8 input cycles plus 8 output cycles, overlapped across banks.
- No combinational path from `m_ready_i` to `s_ready_o`. `full` flags are registered.
- `m_data_o` depends combinationally on registered state only. It does not depend on `s_*` inputs.

## Configuration
- `DCT_TRANSPOSE_PINGPONG_EN` defined: two banks as described; full-rate streaming.
- Not defined: single bank only.
  - `wb` and `rb` are fixed at 0.
  - `s_ready_o` stays low from the acceptance of row 7 until column 7 is read.
  - Throughput is one block per 16 cycles minimum.
  - Ports and latency of the first column are unchanged.

## Test plan
- Single block, 8 rows where sample (r,c)=8r+c, `m_ready_i=1` -> one cycle after row 7, 8 consecutive columns; column c is {c, 8+c, ..., 56+c}. `m_valid_o` then drops.
- Three back-to-back blocks (offsets 0, 64, 128), `s_valid_i=1` and `m_ready_i=1` throughout -> 24 output columns with no gaps. `s_ready_o` never drops (ping-pong).
- Backpressure: hold `m_ready_i=0` for 20 cycles while 2 blocks are offered -> `s_ready_o` falls after 16 rows and `m_data_o` stays at column 0 of block 0. On release, all columns appear in order with no loss.
- Random `s_valid_i`/`m_ready_i` (50%) over 10 blocks of signed values including -32768 and 32767 -> output equals the golden transpose bit-exact.
- Assert `rst_i` after 5 rows of a block -> outputs go to 0 asynchronously. The next fresh 8-row block is transposed correctly with no residue.
- Build without `DCT_TRANSPOSE_PINGPONG_EN`, stream 2 blocks -> `s_ready_o` is low for exactly 8 cycles per block with `m_ready_i=1`. Data is still correct.
